// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default word width, writeback FSM encoding and the
// butterfly pair-to-address mapping used by both scheduler and writeback.
package ntt_pkg;

    localparam int DATA_W = 128;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR_A = 2'd1;
    localparam logic [1:0] ST_WR_B = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WR_A = ST_WR_A,
        WR_B = ST_WR_B,
        FIN  = ST_FIN
    } wb_state_e;

    // Upper index of butterfly j in stage s: insert a zero bit at position s.
    function automatic int unsigned bf_pair_addr(input int unsigned s, input int unsigned j);
        int unsigned lo_mask;
        lo_mask = (32'd1 << s) - 32'd1;
        return ((j >> s) << (s + 32'd1)) | (j & lo_mask);
    endfunction

endpackage

// File: rtl/ntt_writeback_if.sv
// Butterfly result handshake plus coefficient-memory write port.
interface ntt_writeback_if #(
    parameter int DATA_W = ntt_pkg::DATA_W,
    parameter int AW     = 8
);
    logic              bf_vld;
    logic              bf_rdy;
    logic [DATA_W-1:0] bf_ao;
    logic [DATA_W-1:0] bf_bo;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output bf_vld, bf_ao, bf_bo,
        input  bf_rdy, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  bf_vld, bf_ao, bf_bo,
        output bf_rdy, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ntt_wb_fifo.sv
// Small synchronous FIFO holding {ao,bo} result pairs; head is the oldest entry.
module ntt_wb_fifo #(
    parameter  int W     = 256,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [W-1:0]  head_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ntt_writeback.sv
// NTT writeback: buffers butterfly pairs and serialises each into two memory
// writes at stage/pair-derived addresses, pulsing done after the last stage.
module ntt_writeback
    import ntt_pkg::*;
#(
    parameter  int DATA_W     = ntt_pkg::DATA_W,
    parameter  int WORDS      = 256,
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(WORDS),
    localparam int STAGES     = AW,
    localparam int SW         = $clog2(STAGES) + 1,
    localparam int PAIRS      = WORDS / 2,
    localparam int JW         = AW - 1,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic [SW-1:0]        stage_o,
    output logic                 done_o,
    output logic [1:0]           err_o,
    ntt_writeback_if.slave       bus
);
    wb_state_e         state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [JW-1:0]     pair_q, pair_d;
    logic              busy_q, busy_d;
    logic [1:0]        err_q, err_d;

    // Two register stages on the write port: FSM decision, then output pins.
    logic              we1_q, we1_d, done1_q, done1_d;
    logic [AW-1:0]     addr1_q, addr1_d;
    logic [DATA_W-1:0] wd1_q, wd1_d;
    logic              we2_q, done2_q;
    logic [AW-1:0]     addr2_q;
    logic [DATA_W-1:0] wd2_q;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [2*DATA_W-1:0] fifo_head;
    logic [AW-1:0]       addr_a, addr_b;

    assign bus.bf_rdy = busy_q && (fifo_count < CW'(FIFO_DEPTH));
    assign fifo_push  = bus.bf_vld && bus.bf_rdy;

    ntt_wb_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({bus.bf_ao, bus.bf_bo}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign addr_a = AW'(bf_pair_addr(32'(stage_q), 32'(pair_q)));
    assign addr_b = addr_a + (AW'(1) << stage_q);

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        pair_d   = pair_q;
        busy_d   = busy_q;
        err_d    = err_q;
        we1_d    = 1'b0;
        addr1_d  = addr1_q;
        wd1_d    = wd1_q;
        done1_d  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = WR_A;
                busy_d  = 1'b1;
                stage_d = '0;
                pair_d  = '0;
                err_d   = '0;
            end
            WR_A: if (!fifo_empty) begin
                we1_d   = 1'b1;
                addr1_d = addr_a;
                wd1_d   = fifo_head[2*DATA_W-1:DATA_W];
                state_d = WR_B;
            end
            WR_B: begin
                we1_d    = 1'b1;
                addr1_d  = addr_b;
                wd1_d    = fifo_head[DATA_W-1:0];
                fifo_pop = 1'b1;
                state_d  = WR_A;
                if (pair_q == JW'(PAIRS - 1)) begin
                    pair_d  = '0;
                    stage_d = stage_q + SW'(1);
                    if (stage_q == SW'(STAGES - 1)) state_d = FIN;
                end else begin
                    pair_d = pair_q + JW'(1);
                end
            end
            FIN: begin
                done1_d = 1'b1;
                busy_d  = 1'b0;
                stage_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Drops are flagged after the start clear so a same-cycle drop still sticks.
        if (bus.bf_vld && busy_q && fifo_full) err_d[0] = 1'b1;
        if (bus.bf_vld && !busy_q)             err_d[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            stage_q <= '0;
            pair_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= '0;
            we1_q   <= 1'b0;
            addr1_q <= '0;
            wd1_q   <= '0;
            done1_q <= 1'b0;
            we2_q   <= 1'b0;
            addr2_q <= '0;
            wd2_q   <= '0;
            done2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            pair_q  <= pair_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            we1_q   <= we1_d;
            addr1_q <= addr1_d;
            wd1_q   <= wd1_d;
            done1_q <= done1_d;
            we2_q   <= we1_q;
            addr2_q <= addr1_q;
            wd2_q   <= wd1_q;
            done2_q <= done1_q;
        end
    end

    assign bus.mem_we    = we2_q;
    assign bus.mem_addr  = addr2_q;
    assign bus.mem_wdata = wd2_q;
    assign busy_o        = busy_q;
    assign stage_o       = stage_q;
    assign done_o        = done2_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ntt_writeback.sv
// Directed bench for ntt_writeback (WORDS=16, FIFO_DEPTH=4, 32-bit words).
module tb_ntt_writeback;
    localparam int DW = 32;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [2:0] stage;
    logic [1:0] err;

    ntt_writeback_if #(.DATA_W(DW), .AW(AW)) bus ();

    ntt_writeback #(.DATA_W(DW), .WORDS(16), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (start),
        .busy_o  (busy),
        .stage_o (stage),
        .done_o  (done),
        .err_o   (err),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    int unsigned   wa[$];
    logic [DW-1:0] wd[$];
    int            wc[$];
    int            acc[$];

    // Hand-derived upper address per pair k = stage*8 + j.
    int unsigned addr_tab [32] = '{0, 2, 4, 6, 8, 10, 12, 14,
                                   0, 1, 4, 5, 8, 9, 12, 13,
                                   0, 1, 2, 3, 8, 9, 10, 11,
                                   0, 1, 2, 3, 4, 5, 6, 7};
    bit ov_rdy [8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    int ov_src [7] = '{0, 1, 2, 3, 4, 5, 7};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.mem_we) begin
            wa.push_back(32'(bus.mem_addr));
            wd.push_back(bus.mem_wdata);
            wc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
        logic rdy;
        rdy = bus.bf_rdy;
        bus.bf_vld = 1'b1;
        bus.bf_ao  = a;
        bus.bf_bo  = b;
        @(negedge clk);
        bus.bf_vld = 1'b0;
        if (rdy) acc.push_back(cyc);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(input int start_cnt);
        for (int i = 0; i < 40 && done_cnt == start_cnt; i++) @(negedge clk);
    endtask

    initial begin
        int dc0;
        bus.bf_vld = 1'b0;
        bus.bf_ao  = '0;
        bus.bf_bo  = '0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stage", stage, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", bus.bf_rdy, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Result while idle
        for (int i = 0; i < 2; i++) begin
            chk("idle_rdy", bus.bf_rdy, 0);
            bus.bf_vld = 1'b1;
            bus.bf_ao  = 32'h1111_1111;
            bus.bf_bo  = 32'h2222_2222;
            @(negedge clk);
        end
        bus.bf_vld = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_err", err, 2'b10);
        chk("idle_nwr", wa.size(), 0);

        // Full run, with a stall after pair 10
        pulse_start();
        chk("run_busy", busy, 1);
        chk("run_err_clr", err, 0);
        chk("run_stage0", stage, 0);
        acc.delete();
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                send_pair(32'hA000_0000 + k, 32'hB000_0000 + k, 0);
                for (int g = 1; g <= 6; g++) begin
                    @(negedge clk);
                    if (g >= 4) chk("stall_we", bus.mem_we, 0);
                end
            end else begin
                send_pair(32'hA000_0000 + k, 32'hB000_0000 + k, 1);
            end
        end
        wait_done(0);
        repeat (4) @(negedge clk);
        chk("run_done_cnt", done_cnt, 1);
        chk("run_nacc", acc.size(), 32);
        chk("run_nwr", wa.size(), 64);
        chk("run_busy_end", busy, 0);
        chk("run_stage_end", stage, 0);
        if (wa.size() == 64 && acc.size() == 32) begin
            chk("lat_a0", wc[0], acc[0] + 2);
            chk("lat_b0", wc[1], acc[0] + 3);
            chk("done_cyc", done_cyc, wc[63] + 1);
            chk("s1p3_a", wa[22], 5);
            chk("s1p3_b", wa[23], 7);
            chk("s2p5_a", wa[42], 9);
            chk("s2p5_b", wa[43], 13);
            chk("s3p7_a", wa[62], 7);
            chk("s3p7_b", wa[63], 15);
            for (int k = 0; k < 32; k++) begin
                chk("run_addr_a", wa[2*k], addr_tab[k]);
                chk("run_addr_b", wa[2*k+1], addr_tab[k] + (32'd1 << (k / 8)));
                chk("run_data_a", wd[2*k], 32'hA000_0000 + k);
                chk("run_data_b", wd[2*k+1], 32'hB000_0000 + k);
            end
        end

        // Overflow: one pair per cycle for 8 cycles
        wa.delete(); wd.delete(); wc.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            chk("ov_rdy", bus.bf_rdy, ov_rdy[i]);
            bus.bf_vld = 1'b1;
            bus.bf_ao  = 32'hC000_0000 + i;
            bus.bf_bo  = 32'hD000_0000 + i;
            @(negedge clk);
        end
        bus.bf_vld = 1'b0;
        for (int i = 0; i < 40 && wa.size() < 14; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("ov_nwr", wa.size(), 14);
        chk("ov_err", err, 2'b01);
        if (wa.size() == 14) begin
            for (int m = 0; m < 7; m++) begin
                chk("ov_addr_a", wa[2*m], 2 * m);
                chk("ov_addr_b", wa[2*m+1], 2 * m + 1);
                chk("ov_data_a", wd[2*m], 32'hC000_0000 + ov_src[m]);
                chk("ov_data_b", wd[2*m+1], 32'hD000_0000 + ov_src[m]);
            end
        end
        for (int k = 7; k < 32; k++) send_pair(32'hE000_0000 + k, 32'hF000_0000 + k, 1);
        wait_done(1);
        repeat (3) @(negedge clk);
        chk("ov_done_cnt", done_cnt, 2);
        pulse_start();
        chk("restart_err_clr", err, 0);

        // Mid-run reset with pairs still buffered
        for (int k = 0; k < 3; k++) send_pair(32'h5500_0000 + k, 32'h6600_0000 + k, 0);
        rstn = 1'b0;
        dc0 = done_cnt;
        wa.delete(); wd.delete(); wc.delete();
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_rdy", bus.bf_rdy, 0);
        chk("mrst_we", bus.mem_we, 0);
        chk("mrst_stage", stage, 0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("mrst_no_done", done_cnt, dc0);
        chk("mrst_nwr", wa.size(), 0);
        pulse_start();
        send_pair(32'h7777_0001, 32'h8888_0001, 1);
        repeat (4) @(negedge clk);
        chk("mrst_post_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("mrst_addr_a", wa[0], 0);
            chk("mrst_data_a", wd[0], 32'h7777_0001);
            chk("mrst_addr_b", wa[1], 1);
            chk("mrst_data_b", wd[1], 32'h8888_0001);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
